// File: rtl/tc_link_sequencer.sv
// tc_link_sequencer: buffers TC frame bytes from a valid/ready stream and
// serialises them MSB-first onto the three-wire TC link (active, clock, data).
// Each frame is framed by zero lead-in bits, zero trail-out bits and an
// inter-frame gap with the envelope low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | link quiet, waiting for a complete frame (or a full FIFO)
// S_LEAD  | envelope high, LeadBits zero bits; first byte popped at end
// S_SHIFT | current byte shifted out bit7..bit0
// S_TRAIL | TrailBits zero bits after the last payload bit
// S_GAP   | envelope low for GapBits bit periods between frames
module tc_link_sequencer #(
  parameter int ClkDiv    = 4,
  parameter int FifoDepth = 16,
  parameter int LeadBits  = 8,
  parameter int TrailBits = 2,
  parameter int GapBits   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_last_i,
  output logic        tc_active_o,
  output logic        tc_clk_o,
  output logic        tc_data_o,
  output logic        busy_o,
  output logic        underrun_o,
  output logic [15:0] frames_sent_o
);

  localparam int BitPeriod = 2 * ClkDiv;
  localparam int CntW      = (BitPeriod > 2) ? $clog2(BitPeriod) : 1;
  localparam int AddrW     = $clog2(FifoDepth);
  localparam int CountW    = AddrW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t state, state_next;

  // FIFO storage and bookkeeping
  logic [8:0]        mem [FifoDepth];
  logic [AddrW-1:0]  wr_ptr, rd_ptr;
  logic [CountW-1:0] count;
  logic [CountW-1:0] pending;
  logic              full, empty;
  logic              push, pop;
  logic [8:0]        head;

  // bit timer and per-state bit counter
  logic [CntW-1:0]   cnt;
  logic [15:0]       bit_cnt;
  logic              bit_end;

  // serialiser
  logic [7:0]        shreg;
  logic              cur_last;
  logic              load;

  logic              start_ok;
  logic              underrun_set;
  logic              frame_done;
  logic              underrun_q;
  logic [15:0]       frames_sent_q;

  assign full         = (count == CountW'(FifoDepth));
  assign empty        = (count == '0);
  assign byte_ready_o = ~full;
  assign push         = byte_valid_i & ~full;
  assign head         = mem[rd_ptr];

  assign bit_end  = (cnt == CntW'(BitPeriod - 1));
  assign start_ok = en_i & ((pending != '0) | full);

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {byte_last_i, byte_data_i};
    end
  end

  // FIFO pointers, occupancy and count of complete frames held
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({push & byte_last_i, pop & head[8]})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // next-state, FIFO pop and frame-event decode
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    load         = 1'b0;
    underrun_set = 1'b0;
    frame_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_next = S_LEAD;
      end
      S_LEAD: begin
        if (bit_end && bit_cnt == 16'(LeadBits - 1)) begin
          state_next = S_SHIFT;
          pop        = 1'b1;
          load       = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_end && bit_cnt == 16'd7) begin
          if (cur_last) begin
            state_next = S_TRAIL;
          end else if (!empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            underrun_set = 1'b1;
            state_next   = S_GAP;
          end
        end
      end
      S_TRAIL: begin
        if (bit_end && bit_cnt == 16'(TrailBits - 1)) begin
          state_next = S_GAP;
          frame_done = 1'b1;
        end
      end
      S_GAP: begin
        // chain straight into the next frame so the gap is exactly GapBits
        if (bit_end && bit_cnt == 16'(GapBits - 1)) begin
          state_next = start_ok ? S_LEAD : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // bit timer and bit counter, restarted on every state entry
  always_ff @(posedge clk_i) begin
    if (rst_i || state == S_IDLE || state_next != state) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (bit_end) begin
        if (state == S_SHIFT && bit_cnt == 16'd7) bit_cnt <= '0;
        else                                      bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // shift register: load on pop, shift at the end of each payload bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg    <= '0;
      cur_last <= 1'b0;
    end else if (load) begin
      shreg    <= head[7:0];
      cur_last <= head[8];
    end else if (state == S_SHIFT && bit_end) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  // underrun pulse and completed-frame counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      underrun_q    <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      underrun_q <= underrun_set;
      if (frame_done) frames_sent_q <= frames_sent_q + 16'd1;
    end
  end

  assign tc_active_o   = (state == S_LEAD) || (state == S_SHIFT) || (state == S_TRAIL);
  assign tc_clk_o      = tc_active_o && (cnt >= CntW'(ClkDiv));
  assign tc_data_o     = (state == S_SHIFT) && shreg[7];
  assign busy_o        = (state != S_IDLE);
  assign underrun_o    = underrun_q;
  assign frames_sent_o = frames_sent_q;

endmodule

// File: tb/tb_tc_link_sequencer.sv
// Directed bench for tc_link_sequencer with ClkDiv=4, LeadBits=8,
// TrailBits=2, GapBits=16, FifoDepth=16.
module tb_tc_link_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_last = 1'b0;
  logic        byte_ready;
  logic        tc_active;
  logic        tc_clk;
  logic        tc_data;
  logic        busy;
  logic        underrun;
  logic [15:0] frames_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int und_cnt  = 0;

  tc_link_sequencer #(
    .ClkDiv(4), .FifoDepth(16), .LeadBits(8), .TrailBits(2), .GapBits(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_i(en),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .byte_data_i(byte_data),
    .byte_last_i(byte_last),
    .tc_active_o(tc_active),
    .tc_clk_o(tc_clk),
    .tc_data_o(tc_data),
    .busy_o(busy),
    .underrun_o(underrun),
    .frames_sent_o(frames_sent)
  );

  always #5 clk = ~clk;

  // count underrun pulses
  always @(negedge clk) begin
    if (underrun) und_cnt <= und_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int t = 0;
    while (!byte_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("push_timeout", 256'(byte_ready), 256'd1);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 256'(busy), 256'd0);
  endtask

  // low: negedges waited for the envelope; hi: envelope cycles;
  // nb/bits: data sampled on each tc_clk rising edge
  task automatic capture(output int low, output int hi, output int nb, output logic [255:0] bits);
    logic prev = 1'b0;
    low = 0; hi = 0; nb = 0; bits = '0;
    while (!tc_active && low < 2000) begin
      @(negedge clk);
      low++;
    end
    while (tc_active && hi < 4000) begin
      if (tc_clk && !prev) begin
        bits = {bits[254:0], tc_data};
        nb++;
      end
      prev = tc_clk;
      hi++;
      @(negedge clk);
    end
  endtask

  int low, hi, nb, und_snap, act_seen;
  logic [255:0] bits, exp_bits;
  logic [7:0] b;

  // directed sequence
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", 256'({tc_active, tc_clk, tc_data, busy, underrun, byte_ready}), 256'b000001);
    check("reset_frames", 256'(frames_sent), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // single byte 0xA5
    push(8'hA5, 1'b1);
    check("t1_pre_rise", 256'(tc_active), 256'd0);
    capture(low, hi, nb, bits);
    check("t1_latency", 256'(low), 256'd1);
    check("t1_active_cycles", 256'(hi), 256'd144);
    check("t1_nbits", 256'(nb), 256'd18);
    check("t1_bits", bits, 256'({8'h00, 8'hA5, 2'b00}));
    check("t1_frames", 256'(frames_sent), 256'd1);

    // three frames back-to-back
    push(8'h12, 1'b0); push(8'h34, 1'b1);
    push(8'h56, 1'b1);
    push(8'h9A, 1'b0); push(8'hBC, 1'b0); push(8'hDE, 1'b0); push(8'hF0, 1'b1);
    capture(low, hi, nb, bits);
    check("t2a_active_cycles", 256'(hi), 256'd208);
    check("t2a_bits", bits, 256'({8'h00, 8'h12, 8'h34, 2'b00}));
    capture(low, hi, nb, bits);
    check("t2b_gap", 256'(low), 256'd128);
    check("t2b_active_cycles", 256'(hi), 256'd144);
    check("t2b_bits", bits, 256'({8'h00, 8'h56, 2'b00}));
    capture(low, hi, nb, bits);
    check("t2c_gap", 256'(low), 256'd128);
    check("t2c_active_cycles", 256'(hi), 256'd336);
    check("t2c_nbits", 256'(nb), 256'd42);
    check("t2c_bits", bits, 256'({8'h00, 32'h9ABCDEF0, 2'b00}));
    @(negedge clk);
    check("t2_frames", 256'(frames_sent), 256'd4);
    check("t2_no_underrun", 256'(und_cnt), 256'd0);

    // 16 bytes without last: start on full, then underrun
    wait_idle();
    exp_bits = '0;
    for (int i = 0; i < 16; i++) begin
      b = {4'(i), ~4'(i)};
      exp_bits = {exp_bits[247:0], b};
      push(b, 1'b0);
    end
    check("t3_full_ready", 256'(byte_ready), 256'd0);
    capture(low, hi, nb, bits);
    check("t3_latency", 256'(low), 256'd1);
    check("t3_active_cycles", 256'(hi), 256'd1088);
    check("t3_nbits", 256'(nb), 256'd136);
    check("t3_bits", bits, exp_bits);
    @(negedge clk);
    check("t3_underrun", 256'(und_cnt), 256'd1);
    check("t3_frames", 256'(frames_sent), 256'd4);

    // enable gating
    wait_idle();
    en = 1'b0;
    push(8'h3C, 1'b1);
    act_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tc_active || busy) act_seen++;
    end
    check("t4_blocked", 256'(act_seen), 256'd0);
    en = 1'b1;
    @(negedge clk);
    check("t4_en_rise", 256'(tc_active), 256'd1);
    capture(low, hi, nb, bits);
    check("t4_active_cycles", 256'(hi), 256'd144);
    check("t4_bits", bits, 256'({8'h00, 8'h3C, 2'b00}));
    check("t4_frames", 256'(frames_sent), 256'd5);

    // reset during byte 2 of 4
    wait_idle();
    und_snap = und_cnt;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
    low = 0;
    while (!tc_active && low < 2000) begin
      @(negedge clk);
      low++;
    end
    repeat (150) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_reset_outs", 256'({tc_active, tc_clk, tc_data, busy, underrun, byte_ready}), 256'b000001);
    check("t5_reset_frames", 256'(frames_sent), 256'd0);
    act_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (tc_active || busy) act_seen++;
    end
    check("t5_fifo_flushed", 256'(act_seen), 256'd0);
    check("t5_no_underrun", 256'(und_cnt), 256'(und_snap));
    push(8'hC3, 1'b1);
    capture(low, hi, nb, bits);
    check("t5_latency", 256'(low), 256'd1);
    check("t5_bits", bits, 256'({8'h00, 8'hC3, 2'b00}));
    check("t5_frames", 256'(frames_sent), 256'd1);

    // frame counter wrap
    wait_idle();
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    @(negedge clk);
    push(8'h81, 1'b1);
    capture(low, hi, nb, bits);
    @(negedge clk);
    check("t6_bits", bits, 256'({8'h00, 8'h81, 2'b00}));
    check("t6_wrap", 256'(frames_sent), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
